// File: rtl/pulse_param_pkg.sv
// Shared definitions for the pulse-parameter loader: command IDs, payload
// lengths per ID, power-up/default parameter values and FSM state encoding.
`timescale 1ns/1ps
package pulse_param_pkg;

  localparam logic [7:0] ID_DEFAULTS  = 8'h00;
  localparam logic [7:0] ID_PERIOD    = 8'h01;
  localparam logic [7:0] ID_P1WIDTH   = 8'h02;
  localparam logic [7:0] ID_DELAY     = 8'h03;
  localparam logic [7:0] ID_P2WIDTH   = 8'h04;
  localparam logic [7:0] ID_NUTDEL    = 8'h05;
  localparam logic [7:0] ID_NUTWID    = 8'h06;
  localparam logic [7:0] ID_BLOCK     = 8'h07;
  localparam logic [7:0] ID_BLOCKOFF  = 8'h08;
  localparam logic [7:0] ID_CPMG      = 8'h09;
  localparam logic [7:0] ID_FLAGS     = 8'h0A;

  localparam logic [7:0]  ST_PERIOD   = 8'd1;
  localparam logic [15:0] ST_P1WIDTH  = 16'd30;
  localparam logic [15:0] ST_DELAY    = 16'd200;
  localparam logic [15:0] ST_P2WIDTH  = 16'd60;
  localparam logic [31:0] ST_NUTDEL   = 32'd300;
  localparam logic [31:0] ST_NUTWID   = 32'd300;
  localparam logic [7:0]  ST_BLOCK    = 8'd50;
  localparam logic [15:0] ST_BLOCKOFF = 16'd100;
  localparam logic [7:0]  ST_CPMG     = 8'd1;
  localparam logic        ST_PUMP     = 1'b1;
  localparam logic        ST_BL       = 1'b1;
  localparam logic        ST_NUT      = 1'b1;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PAYLOAD = 1'b1
  } state_e;

  function automatic logic id_valid(input logic [7:0] id);
    return id <= ID_FLAGS;
  endfunction

  // Payload length in bytes; only meaningful when id_valid(id).
  function automatic logic [2:0] id_len(input logic [7:0] id);
    case (id)
      ID_PERIOD, ID_BLOCK, ID_CPMG, ID_FLAGS:          return 3'd1;
      ID_P1WIDTH, ID_DELAY, ID_P2WIDTH, ID_BLOCKOFF:   return 3'd2;
      ID_NUTDEL, ID_NUTWID:                            return 3'd4;
      default:                                         return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/pulse_param_timeout.sv
// Inter-byte timeout: loadable down-counter with terminal-count compare.
// Ports: clk_i, rst_i (sync, active-high), clr_i/load_i (reload to limit),
//        run_i (count idle cycles), expire_o (limit reached, no load this cycle).
`timescale 1ns/1ps
module pulse_param_timeout #(
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] ONE   = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Count holds at one; a byte arriving on the terminal cycle wins via load_i.
  assign expire_o = run_i && !load_i && (cnt_q == ONE);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || load_i)
      cnt_d = LIMIT;
    else if (run_i && cnt_q != ONE)
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= LIMIT;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pulse_param_loader.sv
// Parses framed UART commands (ID byte + MSB-first payload) into the pulse
// parameter register file. Each complete frame updates exactly one parameter
// (or restores all defaults for ID 0x00) and strobes rx_done_o one cycle later.
// Ports: clk_i, resetn_i (sync, active-high: load defaults), rx_byte_i/rx_valid_i
//        (byte stream), parameter outputs, rx_done_o, frame_err_o.
//
// state     | meaning
// S_IDLE    | waiting for an ID byte
// S_PAYLOAD | collecting payload bytes for id_q, timeout running
`timescale 1ns/1ps
module pulse_param_loader
  import pulse_param_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  output logic [7:0]  period_o,
  output logic [15:0] p1width_o,
  output logic [15:0] delay_o,
  output logic [15:0] p2width_o,
  output logic [31:0] nut_del_o,
  output logic [31:0] nut_wid_o,
  output logic [7:0]  pulse_block_o,
  output logic [15:0] pulse_block_off_o,
  output logic [7:0]  cpmg_o,
  output logic        pump_o,
  output logic        block_o,
  output logic        nutation_o,
  output logic        rx_done_o,
  output logic        frame_err_o
);

  state_e      state_q, state_d;
  logic [7:0]  id_q;
  logic [2:0]  bytes_left_q;
  logic [31:0] shift_q, shift_d;
  logic        rx_done_q, frame_err_q;

  logic [7:0]  period_q, pulse_block_q, cpmg_q;
  logic [15:0] p1width_q, delay_q, p2width_q, pulse_block_off_q;
  logic [31:0] nut_del_q, nut_wid_q;
  logic        pump_q, block_q, nutation_q;

  logic start, shift_en, commit, load_defaults, err, expire;

  assign shift_d = {shift_q[23:0], rx_byte_i};

  pulse_param_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (resetn_i),
    .clr_i    (state_q != S_PAYLOAD),
    .load_i   (rx_valid_i),
    .run_i    (state_q == S_PAYLOAD),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i) begin
    if (resetn_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (rx_valid_i && id_valid(rx_byte_i) && id_len(rx_byte_i) != 3'd0)
          state_d = S_PAYLOAD;
      S_PAYLOAD:
        if ((rx_valid_i && bytes_left_q == 3'd1) || expire)
          state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start         = 1'b0;
    shift_en      = 1'b0;
    commit        = 1'b0;
    load_defaults = 1'b0;
    err           = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (rx_valid_i) begin
          if (!id_valid(rx_byte_i))            err           = 1'b1;
          else if (id_len(rx_byte_i) == 3'd0)  load_defaults = 1'b1;
          else                                 start         = 1'b1;
        end
      S_PAYLOAD:
        if (rx_valid_i) begin
          shift_en = 1'b1;
          commit   = (bytes_left_q == 3'd1);
        end else if (expire) begin
          err = 1'b1;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (resetn_i || load_defaults) begin
      period_q          <= ST_PERIOD;
      p1width_q         <= ST_P1WIDTH;
      delay_q           <= ST_DELAY;
      p2width_q         <= ST_P2WIDTH;
      nut_del_q         <= ST_NUTDEL;
      nut_wid_q         <= ST_NUTWID;
      pulse_block_q     <= ST_BLOCK;
      pulse_block_off_q <= ST_BLOCKOFF;
      cpmg_q            <= ST_CPMG;
      pump_q            <= ST_PUMP;
      block_q           <= ST_BL;
      nutation_q        <= ST_NUT;
    end else if (commit) begin
      // Narrow targets take the low bytes; shift_d holds exactly len bytes here.
      case (id_q)
        ID_PERIOD:   period_q          <= shift_d[7:0];
        ID_P1WIDTH:  p1width_q         <= shift_d[15:0];
        ID_DELAY:    delay_q           <= shift_d[15:0];
        ID_P2WIDTH:  p2width_q         <= shift_d[15:0];
        ID_NUTDEL:   nut_del_q         <= shift_d;
        ID_NUTWID:   nut_wid_q         <= shift_d;
        ID_BLOCK:    pulse_block_q     <= shift_d[7:0];
        ID_BLOCKOFF: pulse_block_off_q <= shift_d[15:0];
        ID_CPMG:     cpmg_q            <= shift_d[7:0];
        ID_FLAGS: begin
          pump_q     <= shift_d[0];
          block_q    <= shift_d[1];
          nutation_q <= shift_d[2];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (resetn_i) begin
      id_q         <= 8'd0;
      bytes_left_q <= 3'd0;
      shift_q      <= 32'd0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_done_q   <= commit || load_defaults;
      frame_err_q <= err;
      if (start) begin
        id_q         <= rx_byte_i;
        bytes_left_q <= id_len(rx_byte_i);
        shift_q      <= 32'd0;
      end else if (shift_en) begin
        shift_q      <= shift_d;
        bytes_left_q <= bytes_left_q - 3'd1;
      end
    end
  end

  assign period_o          = period_q;
  assign p1width_o         = p1width_q;
  assign delay_o           = delay_q;
  assign p2width_o         = p2width_q;
  assign nut_del_o         = nut_del_q;
  assign nut_wid_o         = nut_wid_q;
  assign pulse_block_o     = pulse_block_q;
  assign pulse_block_off_o = pulse_block_off_q;
  assign cpmg_o            = cpmg_q;
  assign pump_o            = pump_q;
  assign block_o           = block_q;
  assign nutation_o        = nutation_q;
  assign rx_done_o         = rx_done_q;
  assign frame_err_o       = frame_err_q;

endmodule

// File: tb/tb_pulse_param_loader.sv
`timescale 1ns/1ps
module tb_pulse_param_loader;

  localparam int TO = 40;

  typedef struct packed {
    logic [7:0]  per;
    logic [15:0] p1;
    logic [15:0] dl;
    logic [15:0] p2;
    logic [31:0] nd;
    logic [31:0] nw;
    logic [7:0]  pb;
    logic [15:0] pbo;
    logic [7:0]  cp;
    logic        pump;
    logic        blk;
    logic        nut;
  } prm_t;

  typedef struct {
    bit   is_err;
    time  t;
    prm_t p;
  } ev_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [7:0]  rx_byte = 8'd0;
  logic        rx_valid = 1'b0;
  logic [7:0]  period, pulse_block, cpmg;
  logic [15:0] p1width, delay, p2width, pulse_block_off;
  logic [31:0] nut_del, nut_wid;
  logic        pump, block, nutation, rx_done, frame_err;
  prm_t        dut_p;

  ev_t  sbq[$];
  prm_t model, seen;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pulse_param_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i             (clk),
    .resetn_i          (resetn),
    .rx_byte_i         (rx_byte),
    .rx_valid_i        (rx_valid),
    .period_o          (period),
    .p1width_o         (p1width),
    .delay_o           (delay),
    .p2width_o         (p2width),
    .nut_del_o         (nut_del),
    .nut_wid_o         (nut_wid),
    .pulse_block_o     (pulse_block),
    .pulse_block_off_o (pulse_block_off),
    .cpmg_o            (cpmg),
    .pump_o            (pump),
    .block_o           (block),
    .nutation_o        (nutation),
    .rx_done_o         (rx_done),
    .frame_err_o       (frame_err)
  );

  assign dut_p = {period, p1width, delay, p2width, nut_del, nut_wid,
                  pulse_block, pulse_block_off, cpmg, pump, block, nutation};

  function automatic prm_t defaults();
    prm_t p;
    p.per = 8'd1;    p.p1 = 16'd30;  p.dl = 16'd200; p.p2 = 16'd60;
    p.nd = 32'd300;  p.nw = 32'd300; p.pb = 8'd50;   p.pbo = 16'd100;
    p.cp = 8'd1;     p.pump = 1'b1;  p.blk = 1'b1;   p.nut = 1'b1;
    return p;
  endfunction

  // Payload length in bytes; -1 marks an unknown ID.
  function automatic int plen(input logic [7:0] id);
    case (id)
      8'h00: return 0;
      8'h01, 8'h07, 8'h09, 8'h0A: return 1;
      8'h02, 8'h03, 8'h04, 8'h08: return 2;
      8'h05, 8'h06: return 4;
      default: return -1;
    endcase
  endfunction

  function automatic prm_t apply(input prm_t p_in, input logic [7:0] id, input logic [31:0] v);
    prm_t p = p_in;
    case (id)
      8'h01: p.per = v[7:0];
      8'h02: p.p1  = v[15:0];
      8'h03: p.dl  = v[15:0];
      8'h04: p.p2  = v[15:0];
      8'h05: p.nd  = v;
      8'h06: p.nw  = v;
      8'h07: p.pb  = v[7:0];
      8'h08: p.pbo = v[15:0];
      8'h09: p.cp  = v[7:0];
      8'h0A: begin p.pump = v[0]; p.blk = v[1]; p.nut = v[2]; end
      default: ;
    endcase
    return p;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic expect_ev(input bit e, input time t, input prm_t p);
    ev_t ev;
    ev.is_err = e;
    ev.t      = t;
    ev.p      = p;
    sbq.push_back(ev);
  endtask

  // Complete frame; the byte following any payload byte waits mingap..maxgap cycles.
  task automatic frame(input logic [7:0] id, input logic [31:0] v, input int mingap, input int maxgap);
    int n = plen(id);
    if (n < 0) begin
      expect_ev(1'b1, $time + 10, model);
      put(id);
    end else if (n == 0) begin
      model = defaults();
      expect_ev(1'b0, $time + 10, model);
      put(id);
    end else begin
      put(id);
      for (int i = n - 1; i >= 0; i--) begin
        idle($urandom_range(maxgap, mingap));
        if (i == 0) begin
          model = apply(model, id, v);
          expect_ev(1'b0, $time + 10, model);
        end
        put(v[8*i +: 8]);
      end
    end
  endtask

  // ID plus nsent payload bytes, then silence: exactly TO idle cycles to frame_err.
  task automatic timeout_frame(input logic [7:0] id, input logic [31:0] v, input int nsent);
    put(id);
    for (int i = 0; i < nsent; i++) put(v[8*i +: 8]);
    expect_ev(1'b1, $time + 10 * TO, model);
    idle(TO + 3);
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    idle(2);
    resetn = 1'b0;
    model  = defaults();
  endtask

  always @(negedge clk) begin
    ev_t ev;
    #1;
    if (resetn) begin
      seen = defaults();
    end else if (rx_done || frame_err) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got done=%b err=%b at %0t, want no pulse", rx_done, frame_err, $time);
      end else begin
        ev = sbq.pop_front();
        if (rx_done !== !ev.is_err || frame_err !== ev.is_err || ($time - 1) != ev.t || dut_p !== ev.p) begin
          bad++;
          $display("FAIL event: got done=%b err=%b t=%0t params=%h, want done=%b err=%b t=%0t params=%h",
                   rx_done, frame_err, $time - 1, dut_p, !ev.is_err, ev.is_err, ev.t, ev.p);
        end
        seen = ev.p;
      end
    end else begin
      total++;
      if (dut_p !== seen) begin
        bad++;
        $display("FAIL hold: got params=%h, want %h at %0t", dut_p, seen, $time);
      end
    end
  end

  initial begin
    logic [7:0] rid;
    model = defaults();
    @(negedge clk);
    do_reset();

    total++;
    if (dut_p !== defaults() || rx_done !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got params=%h done=%b err=%b, want %h 0 0", dut_p, rx_done, frame_err, defaults());
    end

    frame(8'h03, 32'h0000_01F4, 0, 0);
    total++;
    if (delay !== 16'd500) begin
      bad++;
      $display("FAIL delay_500: got %0d want 500", delay);
    end

    frame(8'h05, 32'h0001_86A0, 0, 0);
    frame(8'h0A, 32'h0000_0005, 0, 0);
    idle(2);
    total++;
    if (nut_del !== 32'd100000 || pump !== 1'b1 || block !== 1'b0 || nutation !== 1'b1) begin
      bad++;
      $display("FAIL nutdel_flags: got nut_del=%0d flags=%b%b%b want 100000 101", nut_del, pump, block, nutation);
    end

    do_reset();
    timeout_frame(8'h02, 32'h12, 1);
    total++;
    if (p1width !== 16'd30) begin
      bad++;
      $display("FAIL p1width_after_timeout: got %0d want 30", p1width);
    end
    frame(8'h01, 32'h07, 0, 0);

    frame(8'h3C, 32'h0, 0, 0);
    frame(8'h00, 32'h0, 0, 0);

    put(8'h06); put(8'h11); put(8'h22);
    do_reset();
    frame(8'h06, $urandom, 0, 2);

    // Longest tolerated gap, then the exact-limit timeout with no payload bytes.
    frame(8'h02, 32'h0000_ABCD, TO - 1, TO - 1);
    timeout_frame(8'h08, 32'h0, 0);
    timeout_frame(8'h05, $urandom, 3);

    for (int k = 0; k < 80; k++) begin
      rid = 8'($urandom_range(0, 12));
      if (($urandom_range(0, 9)) == 0) rid = 8'($urandom_range(11, 255));
      frame(rid, $urandom, 0, 3);
      idle($urandom_range(0, 2));
    end

    idle(5);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses: got %0d outstanding, want 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
